// File: rtl/shared_resource_arbiter.sv
// Round-robin arbiter that issues one requester operand per cycle into a
// pipelined 16x16 multiplier and returns tagged results on a shared bus.
module shared_resource_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned LATENCY = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     arbiter_req,
    input  logic [32*NUM_REQ-1:0]  resource_input,
    input  logic [NUM_REQ-1:0]     in_valid_to_resource,
    input  logic                   in_flush,
    output logic [NUM_REQ-1:0]     arbiter_grant,
    output logic [31:0]            resource_output,
    output logic [NUM_REQ-1:0]     out_valid_from_resource,
    output logic                   busy,
    output logic [15:0]            op_count
);

    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OPND_W = 16;
    localparam int unsigned CNT_W  = 16;

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] eligible;
    logic [PTR_W-1:0]   scan_idx;
    logic [PTR_W-1:0]   grant_idx;
    logic               accept;
    logic [DATA_W-1:0]  operand;
    logic [DATA_W-1:0]  product;

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [PTR_W-1:0]   tag_q  [LATENCY];
    logic [PTR_W-1:0]   tag_d  [LATENCY];
    logic [DATA_W-1:0]  data_q [LATENCY];
    logic [DATA_W-1:0]  data_d [LATENCY];
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    // Round-robin search for the first eligible requester starting at ptr
    always_comb begin
        arbiter_grant = '0;
        grant_idx     = '0;
        scan_idx      = '0;
        accept        = 1'b0;
        eligible      = arbiter_req & in_valid_to_resource;
        if (!reset && !in_flush) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                scan_idx = PTR_W'((32'(ptr_q) + j) % NUM_REQ);
                if (!accept && eligible[scan_idx]) begin
                    accept                  = 1'b1;
                    grant_idx               = scan_idx;
                    arbiter_grant[scan_idx] = 1'b1;
                end
            end
        end
    end

    // Select the granted operand and form the full-width product
    always_comb begin
        operand = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (arbiter_grant[j]) begin
                operand = resource_input[j*32 +: 32];
            end
        end
        product = DATA_W'(operand[31:16]) * DATA_W'(operand[OPND_W-1:0]);
    end

    // Next state: pointer advance, stage shift, flush, completion count
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = PTR_W'((32'(grant_idx) + 1) % NUM_REQ);
        end

        valid_d    = '0;
        valid_d[0] = accept;
        tag_d[0]   = grant_idx;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            tag_d[i]   = tag_q[i-1];
        end
        if (in_flush) begin
            valid_d = '0;
        end

        // Data only moves with a live operation so the output bus holds otherwise
        data_d[0] = valid_d[0] ? product : data_q[0];
        for (int unsigned i = 1; i < LATENCY; i++) begin
            data_d[i] = valid_d[i] ? data_q[i-1] : data_q[i];
        end

        op_count_d = op_count_q + CNT_W'(valid_d[LATENCY-1]);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            valid_q    <= '0;
            op_count_q <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            valid_q    <= valid_d;
            op_count_q <= op_count_d;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_q[i]  <= tag_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    // Steer the last-stage result back to its originator
    always_comb begin
        out_valid_from_resource = '0;
        if (valid_q[LATENCY-1]) begin
            out_valid_from_resource[tag_q[LATENCY-1]] = 1'b1;
        end
    end

    assign resource_output = data_q[LATENCY-1];
    assign busy            = |valid_q;
    assign op_count        = op_count_q;

endmodule
